// File: rtl/manchester_pkg.sv
// Shared Manchester line-code definitions: decoder state encoding and the bit polarity
// constant, reused by the encoder side.
package manchester_pkg;

  typedef enum logic {
    S_HUNT = 1'b0,
    S_BIT  = 1'b1
  } state_e;

  // Line level in the first half of a '1' cell; a '0' cell uses the complement.
  localparam logic ONE_FIRST_HALF = 1'b1;

  // Data bit carried by a mid-bit transition, given the level after that transition.
  function automatic logic mid_edge_bit(input logic new_level);
    return new_level ^ ONE_FIRST_HALF;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for the asynchronous Manchester line plus a history flop;
// rise/fall flag a change between the synchronized level and its previous value.
module sync_edge_det (
  input  logic clock,
  input  logic reset_b,
  input  logic d_i,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync2_q, hist_q;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign level = sync2_q;
  assign rise  = sync2_q & ~hist_q;
  assign fall  = ~sync2_q & hist_q;

endmodule

// File: rtl/manchester_2_nrz.sv
// Manchester-to-NRZ decoder. Define MANCHESTER_DEC_ERR_EN to abort a frame with code_err on a
// too-early edge; otherwise such edges are ignored and code_err stays 0.
module manchester_2_nrz
  import manchester_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic clock,
  input  logic reset_b,
  input  logic B_in,
  output logic B_out,
  output logic B_valid,
  output logic eof,
  output logic code_err,
  output logic busy
);

`ifdef MANCHESTER_DEC_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  localparam int unsigned CntW  = $clog2(3 * HALF_PERIOD) + 1;
  localparam int unsigned IdleW = $clog2(2 * HALF_PERIOD + 1);

  // cnt_q holds cycles since the last accepted mid-bit edge.
  localparam logic [CntW-1:0]  EarlyLim = CntW'(HALF_PERIOD / 2);
  localparam logic [CntW-1:0]  MidLo    = CntW'(3 * HALF_PERIOD / 2);
  localparam logic [CntW-1:0]  Timeout  = CntW'(5 * HALF_PERIOD / 2);
  localparam logic [IdleW-1:0] IdleSat  = IdleW'(2 * HALF_PERIOD);

  logic level, rise, fall, edge_seen;

  sync_edge_det u_sync_edge_det (
    .clock   (clock),
    .reset_b (reset_b),
    .d_i     (B_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  assign edge_seen = rise | fall;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             b_out_q, b_out_d;
  logic             b_valid_q, b_valid_d;
  logic             eof_q, eof_d;
  logic             code_err_q, code_err_d;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= S_HUNT;
      cnt_q      <= '0;
      idle_q     <= '0;
      b_out_q    <= 1'b0;
      b_valid_q  <= 1'b0;
      eof_q      <= 1'b0;
      code_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      b_out_q    <= b_out_d;
      b_valid_q  <= b_valid_d;
      eof_q      <= eof_d;
      code_err_q <= code_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idle_d     = idle_q;
    b_out_d    = b_out_q;
    b_valid_d  = 1'b0;
    eof_d      = 1'b0;
    code_err_d = 1'b0;
    case (state_q)
      S_HUNT: begin
        cnt_d = '0;
        if (rise && (idle_q == IdleSat)) begin
          // Mid-bit rise of the start bit: aligns the cell timing, produces no data.
          state_d = S_BIT;
          idle_d  = '0;
        end else if (level) begin
          idle_d = '0;
        end else if (idle_q != IdleSat) begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_BIT: begin
        // Timeout is checked first so it wins over a coincident edge.
        if (cnt_q == Timeout) begin
          eof_d   = 1'b1;
          state_d = S_HUNT;
          cnt_d   = '0;
          idle_d  = '0;
        end else if (edge_seen && (cnt_q >= MidLo)) begin
          b_valid_d = 1'b1;
          b_out_d   = mid_edge_bit(level);
          cnt_d     = '0;
        end else if (ErrEn && edge_seen && (cnt_q < EarlyLim)) begin
          code_err_d = 1'b1;
          state_d    = S_HUNT;
          cnt_d      = '0;
          idle_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  assign B_out    = b_out_q;
  assign B_valid  = b_valid_q;
  assign eof      = eof_q;
  assign code_err = code_err_q;
  assign busy     = (state_q == S_BIT);

endmodule

// File: tb/tb_manchester_2_nrz.sv
// Self-checking bench for manchester_2_nrz: table of frames plus hand-written corner sequences,
// decoded bits checked against a scoreboard queue filled by the bench-side encoder.
module tb_manchester_2_nrz;

  localparam int H      = 4;
  // cnt runs 0..5H/2 starting in the B_valid cycle; eof is registered one cycle later.
  localparam int EofGap = 5 * H / 2 + 1;

  logic clock, reset_b, B_in;
  logic B_out, B_valid, eof, code_err, busy;

  manchester_2_nrz #(.HALF_PERIOD(H)) dut (
    .clock    (clock),
    .reset_b  (reset_b),
    .B_in     (B_in),
    .B_out    (B_out),
    .B_valid  (B_valid),
    .eof      (eof),
    .code_err (code_err),
    .busy     (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [63:0] bits;
    int          nbits;
    int          h1;
    int          h2;
    int          exp_valid;
    int          exp_eof;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc = 0, last_valid_cyc = 0, eof_gap = -1;
  int   valid_cnt = 0, eof_cnt = 0, err_cnt = 0, busy_cyc = 0;
  logic err_busy = 1'b1;
  logic exp_q[$];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every B_valid.
  initial begin
    logic e;
    forever begin
      @(negedge clock);
      cyc++;
      if (busy) busy_cyc++;
      if (B_valid || eof || code_err) begin
        n_checks++;
        if ((B_valid && eof) || (B_valid && code_err) || (eof && code_err)) begin
          n_fail++;
          $display("FAIL pulse_exclusive: B_valid=%0b eof=%0b code_err=%0b, required one-hot",
                   B_valid, eof, code_err);
        end
      end
      if (B_valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: B_out=%0b, required no B_valid", B_out);
        end else begin
          e = exp_q.pop_front();
          if (B_out !== e) begin
            n_fail++;
            $display("FAIL decoded_bit: B_out=%0b, required %0b", B_out, e);
          end
        end
      end
      if (eof) begin
        eof_cnt++;
        eof_gap = cyc - last_valid_cyc;
      end
      if (code_err) begin
        err_cnt++;
        err_busy = busy;
      end
    end
  end

  task automatic hold(input logic lvl, input int n);
    B_in = lvl;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Bit 1 = high then low, bit 0 = low then high.
  task automatic send_bit(input logic b, input int h1, input int h2);
    hold(b, h1);
    hold(~b, h2);
  endtask

  task automatic send_frame(input logic [63:0] bits, input int n, input int h1, input int h2);
    hold(1'b0, 2 * H);
    send_bit(1'b0, h1, h2);
    for (int i = n - 1; i >= 0; i--) begin
      exp_q.push_back(bits[i]);
      send_bit(bits[i], h1, h2);
    end
    hold(1'b0, 6 * H);
  endtask

  function automatic vec_t mk(input logic [63:0] bits, input int n, input int h1, input int h2);
    vec_t v;
    v.bits      = bits;
    v.nbits     = n;
    v.h1        = h1;
    v.h2        = h2;
    v.exp_valid = n;
    v.exp_eof   = 1;
    return v;
  endfunction

  initial begin
    vec_t        tbl[7];
    int          v0, e0, r0, b0;
    logic [63:0] rnd;

    tbl[0] = mk(64'h9,  4, 4, 4);  // 1,0,0,1 nominal
    tbl[1] = mk(64'hB2, 8, 4, 4);
    tbl[2] = mk(64'h1,  1, 4, 4);
    tbl[3] = mk(64'h0,  6, 4, 4);
    tbl[4] = mk(64'hA5, 8, 5, 4);  // 9-clock cells
    tbl[5] = mk(64'h3C, 8, 4, 3);  // 7-clock cells
    tbl[6] = mk(64'h1F, 5, 5, 4);

    // Reset state
    reset_b = 1'b0;
    B_in    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_B_out", int'(B_out), 0);
    check("rst_B_valid", int'(B_valid), 0);
    check("rst_eof", int'(eof), 0);
    check("rst_code_err", int'(code_err), 0);
    check("rst_busy", int'(busy), 0);
    reset_b = 1'b1;

    // Line toggling every 3 clocks with no idle never starts a frame
    v0 = valid_cnt;
    b0 = busy_cyc;
    for (int i = 0; i < 20; i++) begin
      hold(1'b0, 3);
      hold(1'b1, 3);
    end
    hold(1'b0, 4);
    check("toggle_busy_cycles", busy_cyc - b0, 0);
    check("toggle_valids", valid_cnt - v0, 0);
    hold(1'b0, 6 * H);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      v0 = valid_cnt;
      e0 = eof_cnt;
      r0 = err_cnt;
      eof_gap = -1;
      send_frame(tbl[i].bits, tbl[i].nbits, tbl[i].h1, tbl[i].h2);
      check("vec_valids", valid_cnt - v0, tbl[i].exp_valid);
      check("vec_eof", eof_cnt - e0, tbl[i].exp_eof);
      check("vec_code_err", err_cnt - r0, 0);
      check("vec_eof_gap", eof_gap, EofGap);
      check("vec_busy_end", int'(busy), 0);
      check("vec_queue_empty", exp_q.size(), 0);
      exp_q.delete();
    end

    // Extra edge one clock after the start bit's mid-bit edge, then data 1,0
    v0 = valid_cnt;
    e0 = eof_cnt;
    r0 = err_cnt;
    hold(1'b0, 2 * H + H);
    hold(1'b1, 1);
    hold(1'b0, 1);
    hold(1'b1, H - 2);
`ifndef MANCHESTER_DEC_ERR_EN
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
`endif
    send_bit(1'b1, H, H);
    send_bit(1'b0, H, H);
    hold(1'b0, 6 * H);
`ifdef MANCHESTER_DEC_ERR_EN
    check("glitch_code_err", err_cnt - r0, 1);
    check("glitch_busy_at_err", int'(err_busy), 0);
    check("glitch_valids", valid_cnt - v0, 0);
    check("glitch_eof", eof_cnt - e0, 0);
`else
    check("glitch_code_err", err_cnt - r0, 0);
    check("glitch_valids", valid_cnt - v0, 2);
    check("glitch_eof", eof_cnt - e0, 1);
`endif
    check("glitch_queue_empty", exp_q.size(), 0);
    exp_q.delete();

    // Reset pulse during the 3rd data bit aborts the frame silently
    v0 = valid_cnt;
    e0 = eof_cnt;
    r0 = err_cnt;
    hold(1'b0, 2 * H);
    send_bit(1'b0, H, H);
    exp_q.push_back(1'b0);
    send_bit(1'b0, H, H);
    exp_q.push_back(1'b1);
    send_bit(1'b1, H, H);
    hold(1'b1, 2);
    check("midrst_busy_before", int'(busy), 1);
    check("midrst_B_out_before", int'(B_out), 1);
    reset_b = 1'b0;
    #1;
    check("midrst_B_out", int'(B_out), 0);
    check("midrst_B_valid", int'(B_valid), 0);
    check("midrst_eof", int'(eof), 0);
    check("midrst_code_err", int'(code_err), 0);
    check("midrst_busy", int'(busy), 0);
    @(posedge clock);
    #1;
    reset_b = 1'b1;
    hold(1'b1, 2);
    hold(1'b0, H);
    send_bit(1'b1, H, H);
    hold(1'b0, 6 * H);
    check("midrst_valids", valid_cnt - v0, 2);
    check("midrst_no_eof", eof_cnt - e0, 0);
    check("midrst_no_err", err_cnt - r0, 0);
    v0 = valid_cnt;
    e0 = eof_cnt;
    send_frame(64'h6, 4, H, H);
    check("postrst_valids", valid_cnt - v0, 4);
    check("postrst_eof", eof_cnt - e0, 1);
    check("postrst_queue_empty", exp_q.size(), 0);
    exp_q.delete();

    // Loopback of 64 random bits through the bench encoder
    for (int i = 0; i < 64; i++) rnd[i] = 1'($urandom_range(0, 1));
    v0 = valid_cnt;
    e0 = eof_cnt;
    r0 = err_cnt;
    send_frame(rnd, 64, H, H);
    check("loop_valids", valid_cnt - v0, 64);
    check("loop_eof", eof_cnt - e0, 1);
    check("loop_code_err", err_cnt - r0, 0);
    check("loop_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
